// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and default qualification length for the debouncer
package debounce_pkg;
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;
  localparam int DB_CYCLES_DEF = 20;
endpackage

// File: rtl/debounce_if.sv
// debounce_if: switch input plus debounced level/edge outputs; master drives sw, slave (the debouncer) drives db_*
interface debounce_if;
  logic sw;
  logic db_level;
  logic db_rise;
  logic db_fall;
  modport master (output sw, input db_level, db_rise, db_fall);
  modport slave (input sw, output db_level, db_rise, db_fall);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer; ports clk, reset (async active-low, clears to 0), d (async in), q (synchronized out)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk or negedge reset)
    if (!reset) ff_q <= '0;
    else ff_q <= ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/debounce.sv
// debounce: switch debouncer; ports clk, reset (async active-low), io (debounce_if.slave: sw in, db_level/db_rise/db_fall out); DEBOUNCE_SYNC_EN adds a two-flop input synchronizer
module debounce
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input logic     clk,
  input logic     reset,
  debounce_if.slave io
);
  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_CYCLES - 1);
  logic sw_s;
`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(io.sw), .q(sw_s));
`else
  assign sw_s = io.sw;
`endif
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  // state bit 1 is the debounced level (ONE/WAIT0), so pulses come from its edges
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO:  if (sw_s) begin state_d = WAIT1; cnt_d = RELOAD; end
      WAIT1: if (!sw_s) state_d = ZERO;
             else if (cnt_q == '0) state_d = ONE;
             else cnt_d = cnt_q - CNT_W'(1);
      ONE:   if (!sw_s) begin state_d = WAIT0; cnt_d = RELOAD; end
      WAIT0: if (sw_s) state_d = ONE;
             else if (cnt_q == '0) state_d = ZERO;
             else cnt_d = cnt_q - CNT_W'(1);
      default: state_d = ZERO;
    endcase
    rise_d = state_d[1] & ~state_q[1];
    fall_d = ~state_d[1] & state_q[1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  assign io.db_level = state_q[1];
  assign io.db_rise  = rise_q;
  assign io.db_fall  = fall_q;
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: randomized and directed checks of debounce against a run-length reference model
module tb_debounce;
  localparam int D = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  debounce_if dif ();
  debounce #(.DB_CYCLES(D)) dut (.clk(clk), .reset(reset), .io(dif));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: sw_s is sw seen SL edges late; level flips once sw_s has
  // disagreed with it on D+1 consecutive edges
  logic [2:0] hist;
  logic       m_sws, m_lvl, m_rise, m_fall;
  int         run;
  initial begin hist = '0; m_lvl = 0; m_rise = 0; m_fall = 0; run = 0; end
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist = '0; m_lvl = 0; m_rise = 0; m_fall = 0; run = 0;
    end else begin
      m_sws = (SL == 0) ? dif.sw : hist[(SL == 0) ? 0 : SL - 1];
      hist = {hist[1:0], dif.sw};
      m_rise = 0;
      m_fall = 0;
      if (m_sws !== m_lvl) begin
        run++;
        if (run == D + 1) begin
          m_lvl  = ~m_lvl;
          run    = 0;
          m_rise = m_lvl;
          m_fall = ~m_lvl;
        end
      end else run = 0;
    end
  end

  always @(negedge clk) begin
    check("mon_level", dif.db_level, m_lvl);
    check("mon_rise", dif.db_rise, m_rise);
    check("mon_fall", dif.db_fall, m_fall);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    dif.sw = v;
    repeat (n) tick();
  endtask

  task automatic measure(input logic want, output int n, output int rises, output int falls);
    n = 0; rises = 0; falls = 0;
    do begin
      tick();
      n++;
      rises += int'(dif.db_rise);
      falls += int'(dif.db_fall);
    end while (dif.db_level !== want && n < 60);
  endtask

  int n, r, f, minlvl;

  initial begin
    dif.sw = 1'b0;
    #1 reset = 1'b0;
    repeat (3) tick();
    check("rst_level", dif.db_level, 0);
    check("rst_rise", dif.db_rise, 0);
    check("rst_fall", dif.db_fall, 0);
    reset = 1'b1;
    hold(0, 5);
    dif.sw = 1'b1;
    measure(1, n, r, f);
    check("press_lat", n, D + 1 + SL);
    check("press_rise_now", dif.db_rise, 1);
    check("press_rises", r, 1);
    tick();
    check("press_rise_gone", dif.db_rise, 0);
    hold(1, 3);
    dif.sw = 1'b0;
    measure(0, n, r, f);
    check("rel_lat", n, D + 1 + SL);
    check("rel_fall_now", dif.db_fall, 1);
    check("rel_falls", f, 1);
    tick();
    check("rel_fall_gone", dif.db_fall, 0);
    hold(0, 3);
    hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1);
    dif.sw = 1'b1;
    measure(1, n, r, f);
    check("bounce_lat", n, D + 1 + SL);
    check("bounce_rises", r, 1);
    hold(1, 3);
    hold(0, 2);
    dif.sw = 1'b1;
    minlvl = 1; f = 0;
    repeat (20) begin
      tick();
      if (dif.db_level !== 1'b1) minlvl = 0;
      f += int'(dif.db_fall);
    end
    check("glitch_level", minlvl, 1);
    check("glitch_falls", f, 0);
    dif.sw = 1'b0;
    repeat (SL + 2) tick();
    check("wait0_level", dif.db_level, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_level", dif.db_level, 0);
    check("arst_rise", dif.db_rise, 0);
    check("arst_fall", dif.db_fall, 0);
    f = 0;
    repeat (2) begin tick(); f += int'(dif.db_fall); end
    check("arst_nofall", f, 0);
    dif.sw = 1'b1;
    reset = 1'b1;
    measure(1, n, r, f);
    check("rel_rst_lat", n, D + 1 + SL);
    check("rel_rst_rises", r, 1);
    check("rel_rst_falls", f, 0);
    for (int i = 0; i < 300; i++) begin
      dif.sw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 2 * D + 4)) tick();
      if ($urandom_range(0, 29) == 0) begin
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter DB_CYCLES, default 20: consecutive stable cycles of synchronized input required to accept a level change; legal range 1..65535.
REQ-002 Local constant CNT_W = clog2(DB_CYCLES)+1: counter width, derived and not overridable.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-005 sw  input  1  raw, bouncing, asynchronous mechanical switch level.
REQ-006 db_level  output  1  debounced level; feeds the downstream edge-detect stage directly.
REQ-007 db_rise  output  1  one-cycle pulse on the first cycle db_level is 1 after being 0.
REQ-008 db_fall  output  1  one-cycle pulse on the first cycle db_level is 0 after being 1.

Function
REQ-009 sw_s SHALL be sw after the two-flop synchronizer, or sw directly when the synchronizer is compiled out (REQ-024).
REQ-010 FSM states: ZERO, WAIT1, ONE, WAIT0; Moore outputs; db_level = 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-011 ZERO: sw_s=1 -> WAIT1, counter loaded with DB_CYCLES-1; otherwise hold.
REQ-012 WAIT1: sw_s=0 -> ZERO (bounce rejected, no pulse); sw_s=1 and counter=0 -> ONE; otherwise decrement counter by 1.
REQ-013 ONE: sw_s=0 -> WAIT0, counter loaded with DB_CYCLES-1; otherwise hold.
REQ-014 WAIT0: sw_s=1 -> ONE (glitch rejected, no pulse); sw_s=0 and counter=0 -> ZERO; otherwise decrement counter by 1.
REQ-015 Latency: sw_s stable for DB_CYCLES+1 consecutive cycles -> db_level changes exactly DB_CYCLES+1 cycles after the first cycle of the new sw_s value; the synchronizer adds 2 cycles.
REQ-016 Any sw_s reversal during WAIT1/WAIT0 restarts qualification; the counter is reloaded on the next departure from ZERO/ONE and never carries a partial count.
REQ-017 Counter never wraps: it is never decremented at 0, and it is don't-care in ZERO and ONE.
REQ-018 db_rise and db_fall are registered, each high for exactly one cycle per accepted transition, never simultaneously, and never on rejected bounces.
REQ-019 DB_CYCLES=1: WAIT1/WAIT0 last exactly one cycle; same transition rules apply.

Reset
REQ-020 While reset=0: state=ZERO, counter=0, synchronizer flops=0, db_level=0, db_rise=0, db_fall=0.
REQ-021 Reset asserted mid-qualification or in ONE SHALL abort without emitting db_fall.
REQ-022 After reset deasserts with sw held 1, the block SHALL qualify normally and emit db_rise once; no spurious pulses occur at reset release.

Configuration
REQ-023 Macro DEBOUNCE_SYNC_EN selects the input synchronizer.
REQ-024 With DEBOUNCE_SYNC_EN defined: two-flop synchronizer present; sw-to-db_level latency is DB_CYCLES+3. Without it: sw used directly as sw_s (caller guarantees sw is synchronous to clk); latency is DB_CYCLES+1.

Structure
REQ-025 Package debounce_pkg SHALL hold the state typedef (2-bit encoding ZERO=00, WAIT1=01, ONE=10, WAIT0=11) and the default DB_CYCLES constant.
REQ-026 Sub-module sync_2ff (1-bit, async active-low reset to 0) SHALL implement the synchronizer; it is instantiated only under DEBOUNCE_SYNC_EN.
REQ-027 The counter and FSM are kept in the top module; no further hierarchy.

Verification (DB_CYCLES=4, DEBOUNCE_SYNC_EN defined)
REQ-028 Clean press: sw 0->1 held -> db_level=1 exactly 7 cycles later; db_rise high for that one cycle only.
REQ-029 Bounce: sw toggles 1,0,1,0 at 1-cycle intervals, then held 1 -> no db_rise until 7 cycles after the final rise; exactly one db_rise.
REQ-030 Glitch in ONE: sw drops to 0 for 2 cycles -> db_level stays 1; db_fall never asserts.
REQ-031 Release: sw 1->0 held from ONE -> db_level=0 after 7 cycles; single db_fall pulse.
REQ-032 Async reset: reset=0 mid-WAIT0, with no clock edge -> all outputs 0 immediately; no db_fall.
REQ-033 Macro undefined: repeat REQ-028 -> db_level=1 after 5 cycles.
